tpg_lfsr_gen: RTL and testbench
===============================

# tpg_lfsr_gen

Parametrised LFSR test-pattern generator for the BIST path: it produces a maximal-length pseudo-random sequence of WIDTH-bit vectors to drive a circuit under test. It runs one full period per `start`, can be stalled cycle by cycle, accepts a runtime seed, and flags `complete` after the last pattern. It sits between the BIST controller (which drives `start`/`advance`) and the CUT input mux, and replaces the fixed 3-bit generator.

## Interface
- WIDTH, 3, LFSR width in bits; legal range 3..32.
- TAPS, 3'b110, Fibonacci feedback mask, WIDTH bits. Bit i set means state[i] feeds the XOR. Bit WIDTH-1 must be set. The default is x^3+x^2+1 in left-shift form.
- SEED, 1, default seed, WIDTH bits, nonzero.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  begin a run; sampled in IDLE or DONE.
- advance  in  1  step enable in RUN; low stalls the generator.
- seed_load  in  1  capture `seed` into the seed register.
- seed  in  WIDTH  runtime seed value.
- data_out  out  WIDTH  current pattern.
- valid  out  1  `data_out` is a pattern of the active run.
- busy  out  1  high in RUN.
- complete  out  1  high in DONE.
- pattern_count  out  WIDTH+1  number of patterns already consumed in this run.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE → RUN on `start`. DONE → RUN on `start`. RUN ignores `start`. DONE holds until `start`.
- Seed register:
  - Reset value is SEED.
  - `seed_load` in IDLE or DONE writes `seed`. `seed_load` in RUN is ignored.
  - A zero `seed` is replaced by SEED, so the LFSR never locks up.
- Run start: the state loads from the seed register. If `seed_load` and `start` occur in the same cycle, the run uses the new (sanitised) `seed`.
- Next-state function: `{state[WIDTH-2:0], fb}`, where fb = XOR of (state & TAPS).
- Run length L:
  - L = 2^WIDTH − 1 without the macro.
  - L = 2^WIDTH with TPG_ZERO_STATE_EN.
- Step rule:
  - A pattern is consumed on each RUN cycle with `advance`=1.
  - That edge advances the state and increments `pattern_count`.
  - With `advance`=0, state and count hold, and `valid` stays 1.
- End of run: the edge that consumes pattern L−1 (count reaches L) moves the FSM to DONE. In DONE:
  - `valid`=0 and `complete`=1.
  - `data_out` holds the next state, which equals the seed, so the sequence has wrapped.
  - `pattern_count` holds at L.
- Restart from DONE: `pattern_count` clears to 0, and the state reloads from the seed register.
- Reset mid-run: return to IDLE immediately and abort the run. The seed register is also reset to SEED.

## Timing
- Reset values:
  - `data_out` = SEED
  - `valid` = 0, `busy` = 0, `complete` = 0
  - `pattern_count` = 0
- All outputs are registered.
- Latency: `start` sampled at edge N gives `valid`=1, `busy`=1 and `data_out`=seed from edge N onward.
- Successive patterns appear one per cycle while `advance`=1.
- A full run with `advance` held high takes exactly L cycles of `busy`, and `complete` rises at edge N+L.
- `complete` and `busy` are never both high.

## Configuration
- TPG_ZERO_STATE_EN defined:
  - The feedback becomes fb XOR (state[WIDTH-2:0] == 0).
  - This inserts the all-zero pattern between 10…0 and 0…01.
  - The period becomes 2^WIDTH (de Bruijn sequence).
  - `pattern_count` reaches 2^WIDTH.
- TPG_ZERO_STATE_EN not defined: plain maximal LFSR with period 2^WIDTH − 1. The all-zero pattern is never produced.

## Structure
- Package `tpg_pkg`:
  - FSM state enum (IDLE/RUN/DONE).
  - Function computing L from WIDTH.
  - Default tap constants for WIDTH 3..8.
- Sub-module `lfsr_step` (combinational next-state):
  - Parameters WIDTH and TAPS.
  - Holds the zero-state extension under the macro.
  - Reused by the future response compactor (MISR).
- Top-level owns the FSM, the seed register and the counter.

## Test plan
- Default parameters, reset, `start` with `advance`=1 → `data_out` is 001, 010, 101, 011, 111, 110, 100. `complete`=1 at edge 7, and `pattern_count` = 7.
- Same as above with TPG_ZERO_STATE_EN → sequence …, 110, 100, 000, 001. `complete` after 8 patterns.
- `seed_load` with `seed`=000 in IDLE, then `start` → first pattern is 001 (sanitised).
- `advance` low for 3 cycles mid-run → `data_out` and `pattern_count` frozen, `valid`=1. `complete` is delayed by exactly 3 cycles.
- `start` and `seed_load` (`seed`=101) together in DONE → new run begins at 101. `pattern_count`=0 and `complete` drops the same edge.
- Reset asserted at pattern 4 → all outputs return to reset values asynchronously. The next `start` begins at SEED.

Source files
------------

// File: rtl/tpg_pkg.sv
// Shared types and constants for the LFSR test-pattern generator.
// TPG_ZERO_STATE_EN extends the period to 2^WIDTH by inserting the all-zero pattern.
package tpg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tpg_state_e;

    // Maximal-length Fibonacci taps, left-shift form, bit i means state[i] feeds the XOR
    localparam logic [2:0] TAPS_W3 = 3'b110;
    localparam logic [3:0] TAPS_W4 = 4'b1100;
    localparam logic [4:0] TAPS_W5 = 5'b10100;
    localparam logic [5:0] TAPS_W6 = 6'b110000;
    localparam logic [6:0] TAPS_W7 = 7'b1100000;
    localparam logic [7:0] TAPS_W8 = 8'b10111000;

    // Number of patterns in one run for a given LFSR width
    function automatic logic [32:0] run_length(input int unsigned width);
        logic [32:0] full;
        full = 33'd1 << width;
`ifdef TPG_ZERO_STATE_EN
        return full;
`else
        return full - 33'd1;
`endif
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational Fibonacci LFSR next-state; shared with the response compactor.
// TPG_ZERO_STATE_EN splices the all-zero state between 10..0 and 0..01.
module lfsr_step #(
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b110
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_c
);

    logic fb_c;

    always_comb begin
        fb_c = ^(state & TAPS);
`ifdef TPG_ZERO_STATE_EN
        fb_c = fb_c ^ (state[WIDTH-2:0] == '0);
`endif
        next_c = {state[WIDTH-2:0], fb_c};
    end

endmodule

// File: rtl/tpg_lfsr_gen.sv
// BIST pattern generator: one full LFSR period per start, stallable, runtime seed.
// Build option TPG_ZERO_STATE_EN selects the 2^WIDTH de Bruijn period.
module tpg_lfsr_gen
    import tpg_pkg::*;
#(
    parameter int unsigned      WIDTH = 3,
    parameter logic [WIDTH-1:0] TAPS  = 3'b110,
    parameter logic [WIDTH-1:0] SEED  = 3'd1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             advance,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             busy,
    output logic             complete,
    output logic [WIDTH:0]   pattern_count
);

    localparam int unsigned    CNT_W   = WIDTH + 1;
    localparam logic [WIDTH:0] RUN_LEN = CNT_W'(run_length(WIDTH));

    tpg_state_e       state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH:0]   count_d;
    logic [WIDTH:0]   count_inc_c;
    logic [WIDTH-1:0] seed_clean_c;
    logic [WIDTH-1:0] lfsr_next_c;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state  (data_out),
        .next_c (lfsr_next_c)
    );

    // A zero seed would lock the LFSR, so it falls back to the default
    assign seed_clean_c = (seed == '0) ? SEED : seed;
    assign count_inc_c  = pattern_count + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        lfsr_d  = data_out;
        count_d = pattern_count;
        unique case (state_q)
            IDLE, DONE: begin
                if (seed_load) begin
                    seed_d = seed_clean_c;
                end
                if (start) begin
                    state_d = RUN;
                    lfsr_d  = seed_load ? seed_clean_c : seed_q;
                    count_d = '0;
                end
            end
            RUN: begin
                if (advance) begin
                    lfsr_d  = lfsr_next_c;
                    count_d = count_inc_c;
                    if (count_inc_c == RUN_LEN) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status flags are registered copies of the next FSM state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            seed_q        <= SEED;
            data_out      <= SEED;
            pattern_count <= '0;
            valid         <= 1'b0;
            busy          <= 1'b0;
            complete      <= 1'b0;
        end else begin
            state_q       <= state_d;
            seed_q        <= seed_d;
            data_out      <= lfsr_d;
            pattern_count <= count_d;
            valid         <= (state_d == RUN);
            busy          <= (state_d == RUN);
            complete      <= (state_d == DONE);
        end
    end

endmodule

// File: tb/tb_tpg_lfsr_gen.sv
// Scoreboard bench for tpg_lfsr_gen: directed runs followed by random start/advance/seed/reset.
// Honours TPG_ZERO_STATE_EN the same way as the design.
module tb_tpg_lfsr_gen;

    localparam int unsigned W    = 3;
    localparam logic [2:0]  TAPS = 3'b110;
    localparam logic [2:0]  SEED = 3'd1;
`ifdef TPG_ZERO_STATE_EN
    localparam int unsigned L = 8;
`else
    localparam int unsigned L = 7;
`endif

    typedef struct {
        logic [2:0] data;
        logic       valid;
        logic       busy;
        logic       complete;
        logic [3:0] count;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       advance = 1'b0;
    logic       seed_load = 1'b0;
    logic [2:0] seed = 3'd0;
    logic [2:0] data_out;
    logic       valid, busy, complete;
    logic [3:0] pattern_count;

    int total = 0;
    int bad   = 0;
    exp_t exp_q[$];

    // Reference: the whole period as a list; position in it gives each pattern
    logic [2:0] order[L];
    int         m_st;
    logic [2:0] m_seed, m_data;
    int         m_count;

    tpg_lfsr_gen #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .advance       (advance),
        .seed_load     (seed_load),
        .seed          (seed),
        .data_out      (data_out),
        .valid         (valid),
        .busy          (busy),
        .complete      (complete),
        .pattern_count (pattern_count)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] rule_next(input logic [2:0] x);
        logic fb;
        fb = ^(x & TAPS);
`ifdef TPG_ZERO_STATE_EN
        if (x[1:0] == 2'b00) fb = ~fb;
`endif
        return {x[1:0], fb};
    endfunction

    function automatic int pos_of(input logic [2:0] x);
        for (int i = 0; i < int'(L); i++) if (order[i] == x) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_st = 0; m_seed = SEED; m_data = SEED; m_count = 0;
    endtask

    task automatic model_step(input logic st, input logic adv, input logic sl, input logic [2:0] sd);
        if (m_st == 1) begin
            if (adv) begin
                m_count++;
                m_data = order[(pos_of(m_data) + 1) % int'(L)];
                if (m_count == int'(L)) m_st = 2;
            end
        end else begin
            if (sl) m_seed = (sd == 3'd0) ? SEED : sd;
            if (st) begin
                m_st = 1; m_count = 0; m_data = m_seed;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.data     = m_data;
        e.valid    = (m_st == 1);
        e.busy     = (m_st == 1);
        e.complete = (m_st == 2);
        e.count    = 4'(m_count);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic do_rst, input logic st, input logic adv,
                        input logic sl, input logic [2:0] sd);
        @(posedge clock);
        #1;
        if (do_rst) begin
            reset = 1'b0;
            model_reset();
        end else begin
            reset = 1'b1;
        end
        push_expected();
        start = st; advance = adv; seed_load = sl; seed = sd;
        if (!do_rst) model_step(st, adv, sl, sd);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: every negedge the DUT presents one observation to score
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_out", 32'(data_out), 32'(e.data));
                chk("valid", 32'(valid), 32'(e.valid));
                chk("busy", 32'(busy), 32'(e.busy));
                chk("complete", 32'(complete), 32'(e.complete));
                chk("pattern_count", 32'(pattern_count), 32'(e.count));
                chk("busy_and_complete", 32'(busy & complete), 32'd0);
            end
        end
    end

    initial begin
        order[0] = SEED;
        for (int i = 1; i < int'(L); i++) order[i] = rule_next(order[i-1]);
        model_reset();

        // Reset, then a full run with advance high and a few idle DONE cycles
        step(1, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        step(0, 1, 1, 0, 3'd0);
        for (int i = 0; i < int'(L) + 3; i++) step(0, 0, 1, 0, 3'd0);

        // Zero seed loaded in IDLE is sanitised to SEED
        step(1, 0, 0, 0, 3'd0);
        step(0, 0, 0, 1, 3'd0);
        step(0, 1, 1, 0, 3'd0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 3'd0);
        // Three stall cycles mid-run
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 3'd0);
        for (int i = 0; i < int'(L); i++) step(0, 0, 1, 0, 3'd0);

        // start together with seed_load=101 in DONE
        step(0, 1, 1, 1, 3'd5);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 3'd0);
        // Reset mid-run, then restart from SEED
        step(1, 0, 1, 0, 3'd0);
        step(0, 1, 1, 0, 3'd0);
        for (int i = 0; i < int'(L) + 1; i++) step(0, 0, 1, 0, 3'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)));
        end

        repeat (3) @(posedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
